// File: rtl/cap_gain_seq.sv
// Multi-gain capture sequencer: per gain applies relay/LMH/DAC settings, settles,
// then fires LD pulses. Optional DAC-ack watchdog enabled by CAP_DAC_TIMEOUT_EN.
module cap_gain_seq #(
  parameter int CYC_W  = 18,
  parameter int DEL_W  = 32,
  parameter int DAC_W  = 32,
  parameter int LMH_W  = 6,
  parameter int RLY_W  = 4,
  parameter int DAC_TO = 1024
) (
  input  logic                 clk125,
  input  logic                 rst,
  input  logic                 cap_trig,
  input  logic                 cap_abort,
  input  logic [2:0]           cap_gain_number,
  input  logic [DEL_W-1:0]     cap_gain_del,
  input  logic [4*CYC_W-1:0]   cap_cycle_bus,
  input  logic [4*DEL_W-1:0]   cap_lddel_bus,
  input  logic [4*DAC_W-1:0]   cap_daca_bus,
  input  logic [4*DAC_W-1:0]   cap_dacb_bus,
  input  logic [4*LMH_W-1:0]   cap_lmh_bus,
  input  logic [4*RLY_W-1:0]   cap_relay_bus,
  input  logic                 dac_ack,
  output logic                 dac_req,
  output logic [DAC_W-1:0]     dac_a,
  output logic [DAC_W-1:0]     dac_b,
  output logic [LMH_W-1:0]     lmh_out,
  output logic [RLY_W-1:0]     relay_out,
  output logic                 ld_fire,
  output logic [1:0]           cap_gain_idx,
  output logic                 cap_cing,
  output logic                 cap_cmpt,
  output logic                 cap_abtd,
  output logic                 cap_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_FIRE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [2:0]         r_cnt;
  logic [1:0]         r_idx;
  logic [CYC_W-1:0]   r_cyc;
  logic [DEL_W-1:0]   r_del;
  logic [DAC_W-1:0]   r_dac_a, r_dac_b;
  logic [LMH_W-1:0]   r_lmh;
  logic [RLY_W-1:0]   r_relay;
  logic               r_abtd;

  logic               w_start, w_abort, w_tmo, w_more, w_enter;
  logic [2:0]         w_cnt_clamp;
  logic [1:0]         w_tgt_idx;
  logic [CYC_W-1:0]   w_cyc_tgt;
  logic [DEL_W-1:0]   w_lddel_cur;

  if (DAC_TO < 1) begin : g_bad_dac_to
    $error("DAC_TO must be at least 1");
  end

  assign w_start   = (r_state == S_IDLE) && cap_trig && !cap_abort;
  assign w_abort   = (r_state != S_IDLE) && cap_abort;
  assign w_more    = ({1'b0, r_idx} + 3'd1) < r_cnt;
  // Gain whose settings are loaded when APPLY is entered (from IDLE or NEXT).
  assign w_tgt_idx = (r_state == S_IDLE) ? 2'd0 : r_idx + 2'd1;
  assign w_enter   = (w_next == S_APPLY) && (r_state != S_APPLY);
  assign w_cyc_tgt   = cap_cycle_bus[w_tgt_idx*CYC_W +: CYC_W];
  assign w_lddel_cur = cap_lddel_bus[r_idx*DEL_W +: DEL_W];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_clamp = cap_gain_number;
    if (cap_gain_number == 3'd0)      w_cnt_clamp = 3'd1;
    else if (cap_gain_number > 3'd4) w_cnt_clamp = 3'd4;
  end

`ifdef CAP_DAC_TIMEOUT_EN
  localparam int WD_W = $clog2(DAC_TO + 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  assign w_tmo   = dac_req && !dac_ack && (r_wdog == WD_W'(DAC_TO - 1));
  assign cap_err = r_err;

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (dac_req) r_wdog <= r_wdog + WD_W'(1);
      else         r_wdog <= '0;
      if (w_start)    r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign cap_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort || w_tmo) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_start) w_next = S_APPLY;
        S_APPLY:  if (r_cyc == '0) w_next = S_NEXT;
                  else if (dac_ack) w_next = S_SETTLE;
        S_SETTLE: if (r_del <= DEL_W'(1)) w_next = S_FIRE;
        S_FIRE:   if (r_cyc <= CYC_W'(1)) w_next = S_NEXT;
                  else if (w_lddel_cur != '0) w_next = S_WAIT;
        S_WAIT:   if (r_del <= DEL_W'(1)) w_next = S_FIRE;
        S_NEXT:   w_next = w_more ? S_APPLY : S_DONE;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dac_req  = 1'b0;
    ld_fire  = 1'b0;
    cap_cing = 1'b0;
    cap_cmpt = 1'b0;
    unique case (r_state)
      S_APPLY: begin
        cap_cing = 1'b1;
        dac_req  = (r_cyc != '0);
      end
      S_SETTLE, S_WAIT, S_NEXT: cap_cing = 1'b1;
      S_FIRE: begin
        cap_cing = 1'b1;
        ld_fire  = !cap_abort;
      end
      S_DONE:  cap_cmpt = !cap_abort;
      default: ;
    endcase
  end

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_cyc   <= '0;
      r_del   <= '0;
      r_dac_a <= '0;
      r_dac_b <= '0;
      r_lmh   <= '0;
      r_relay <= '0;
      r_abtd  <= 1'b0;
    end else begin
      r_abtd <= w_abort || w_tmo;

      if (w_start) begin
        r_cnt <= w_cnt_clamp;
        r_idx <= 2'd0;
      end else if (r_state == S_NEXT && w_next == S_APPLY) begin
        r_idx <= r_idx + 2'd1;
      end

      if (w_enter) begin
        r_cyc <= w_cyc_tgt;
        r_del <= cap_gain_del;
        // A gain with zero pulses is skipped without touching the front-end.
        if (w_cyc_tgt != '0) begin
          r_relay <= cap_relay_bus[w_tgt_idx*RLY_W +: RLY_W];
          r_lmh   <= cap_lmh_bus[w_tgt_idx*LMH_W +: LMH_W];
          r_dac_a <= cap_daca_bus[w_tgt_idx*DAC_W +: DAC_W];
          r_dac_b <= cap_dacb_bus[w_tgt_idx*DAC_W +: DAC_W];
        end
      end else begin
        case (r_state)
          S_SETTLE, S_WAIT: r_del <= (r_del == '0) ? '0 : r_del - DEL_W'(1);
          S_FIRE: begin
            r_cyc <= (r_cyc == '0) ? '0 : r_cyc - CYC_W'(1);
            if (w_lddel_cur != '0) r_del <= w_lddel_cur;
          end
          default: ;
        endcase
      end

      if (w_abort || w_tmo) begin
        r_relay <= '0;
        r_lmh   <= '0;
      end
    end
  end

  assign dac_a        = r_dac_a;
  assign dac_b        = r_dac_b;
  assign lmh_out      = r_lmh;
  assign relay_out    = r_relay;
  assign cap_gain_idx = r_idx;
  assign cap_abtd     = r_abtd;

endmodule

// File: tb/tb_cap_gain_seq.sv
// Self-checking bench for cap_gain_seq: directed and randomized runs compared
// against a timeline model computed from gain configuration.
module tb_cap_gain_seq;
  localparam int CYC_W = 18;
  localparam int DEL_W = 32;
  localparam int DAC_W = 32;
  localparam int LMH_W = 6;
  localparam int RLY_W = 4;
`ifdef CAP_DAC_TIMEOUT_EN
  localparam int TB_DAC_TO = 16;
`else
  localparam int TB_DAC_TO = 1024;
`endif

  logic                 clk125 = 1'b0;
  logic                 rst = 1'b1;
  logic                 cap_trig = 1'b0;
  logic                 cap_abort = 1'b0;
  logic [2:0]           cap_gain_number = '0;
  logic [DEL_W-1:0]     cap_gain_del = '0;
  logic [4*CYC_W-1:0]   cap_cycle_bus = '0;
  logic [4*DEL_W-1:0]   cap_lddel_bus = '0;
  logic [4*DAC_W-1:0]   cap_daca_bus = '0;
  logic [4*DAC_W-1:0]   cap_dacb_bus = '0;
  logic [4*LMH_W-1:0]   cap_lmh_bus = '0;
  logic [4*RLY_W-1:0]   cap_relay_bus = '0;
  logic                 dac_ack = 1'b0;
  logic                 dac_req;
  logic [DAC_W-1:0]     dac_a, dac_b;
  logic [LMH_W-1:0]     lmh_out;
  logic [RLY_W-1:0]     relay_out;
  logic                 ld_fire;
  logic [1:0]           cap_gain_idx;
  logic                 cap_cing, cap_cmpt, cap_abtd, cap_err;

  cap_gain_seq #(
    .CYC_W(CYC_W), .DEL_W(DEL_W), .DAC_W(DAC_W),
    .LMH_W(LMH_W), .RLY_W(RLY_W), .DAC_TO(TB_DAC_TO)
  ) dut (
    .clk125(clk125), .rst(rst), .cap_trig(cap_trig), .cap_abort(cap_abort),
    .cap_gain_number(cap_gain_number), .cap_gain_del(cap_gain_del),
    .cap_cycle_bus(cap_cycle_bus), .cap_lddel_bus(cap_lddel_bus),
    .cap_daca_bus(cap_daca_bus), .cap_dacb_bus(cap_dacb_bus),
    .cap_lmh_bus(cap_lmh_bus), .cap_relay_bus(cap_relay_bus),
    .dac_ack(dac_ack), .dac_req(dac_req), .dac_a(dac_a), .dac_b(dac_b),
    .lmh_out(lmh_out), .relay_out(relay_out), .ld_fire(ld_fire),
    .cap_gain_idx(cap_gain_idx), .cap_cing(cap_cing), .cap_cmpt(cap_cmpt),
    .cap_abtd(cap_abtd), .cap_err(cap_err)
  );

  always #5 clk125 = ~clk125;

  int n_checks = 0;
  int n_errors = 0;

  // Configuration of the run under test.
  int             cfg_cnt, cfg_gdel;
  int             cyc_cfg[4], lddel_cfg[4];
  logic [DAC_W-1:0] daca_cfg[4], dacb_cfg[4];
  logic [LMH_W-1:0] lmh_cfg[4];
  logic [RLY_W-1:0] rly_cfg[4];

  // Expected timeline (cycle offsets from the first cycle after the trigger).
  int exp_t[$], exp_g[$], exp_req_t[$], exp_req_g[$];
  int exp_done, exp_n;

  // Monitor records.
  int cyc_now = 0;
  int fire_t[$];
  logic [1:0] fire_idx[$];
  logic [RLY_W-1:0] fire_rly[$];
  logic [LMH_W-1:0] fire_lmh[$];
  int req_t[$];
  logic [DAC_W-1:0] req_a[$], req_b[$];
  int cmpt_t[$], abtd_t[$], rise_t[$], fall_t[$];
  int n_req_cyc = 0;
  logic req_prev = 1'b0, cing_prev = 1'b0;

  int base;
  int m_fire, m_req, m_cmpt, m_abtd, m_rise, m_fall, m_reqcyc;

  bit ack_en = 1'b1;
  int req_age = 0;

  always @(posedge clk125) cyc_now <= cyc_now + 1;

  always @(negedge clk125) begin
    if (ld_fire) begin
      fire_t.push_back(cyc_now);
      fire_idx.push_back(cap_gain_idx);
      fire_rly.push_back(relay_out);
      fire_lmh.push_back(lmh_out);
    end
    if (dac_req) n_req_cyc <= n_req_cyc + 1;
    if (dac_req && !req_prev) begin
      req_t.push_back(cyc_now);
      req_a.push_back(dac_a);
      req_b.push_back(dac_b);
    end
    if (cap_cmpt) cmpt_t.push_back(cyc_now);
    if (cap_abtd) abtd_t.push_back(cyc_now);
    if (cap_cing && !cing_prev) rise_t.push_back(cyc_now);
    if (!cap_cing && cing_prev) fall_t.push_back(cyc_now);
    req_prev  <= dac_req;
    cing_prev <= cap_cing;
  end

  // DAC loader stand-in: acks one cycle after it first sees a request.
  always @(posedge clk125) begin
    #1;
    if (dac_ack) begin
      dac_ack = 1'b0;
      req_age = 0;
    end else if (dac_req && ack_en) begin
      if (req_age >= 1) dac_ack = 1'b1;
      req_age++;
    end else begin
      req_age = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cfg();
    cap_gain_number = 3'(cfg_cnt);
    cap_gain_del    = DEL_W'(cfg_gdel);
    for (int g = 0; g < 4; g++) begin
      cap_cycle_bus[g*CYC_W +: CYC_W] = CYC_W'(cyc_cfg[g]);
      cap_lddel_bus[g*DEL_W +: DEL_W] = DEL_W'(lddel_cfg[g]);
      cap_daca_bus[g*DAC_W +: DAC_W]  = daca_cfg[g];
      cap_dacb_bus[g*DAC_W +: DAC_W]  = dacb_cfg[g];
      cap_lmh_bus[g*LMH_W +: LMH_W]   = lmh_cfg[g];
      cap_relay_bus[g*RLY_W +: RLY_W] = rly_cfg[g];
    end
  endtask

  task automatic random_words();
    for (int g = 0; g < 4; g++) begin
      daca_cfg[g] = $urandom;
      dacb_cfg[g] = $urandom;
      lmh_cfg[g]  = LMH_W'($urandom);
      rly_cfg[g]  = RLY_W'($urandom);
    end
  endtask

  // Timeline: a pulsed gain takes 2 request cycles, max(del,1) settle, its
  // pulses spaced lddel+1 apart, then one NEXT cycle; a skipped gain takes 2.
  task automatic build_model();
    int t;
    exp_t.delete(); exp_g.delete(); exp_req_t.delete(); exp_req_g.delete();
    exp_n = (cfg_cnt == 0) ? 1 : (cfg_cnt > 4) ? 4 : cfg_cnt;
    t = 0;
    for (int g = 0; g < exp_n; g++) begin
      if (cyc_cfg[g] == 0) begin
        t += 2;
      end else begin
        exp_req_t.push_back(t);
        exp_req_g.push_back(g);
        t += 2 + ((cfg_gdel == 0) ? 1 : cfg_gdel);
        for (int p = 0; p < cyc_cfg[g]; p++) begin
          exp_t.push_back(t);
          exp_g.push_back(g);
          t += (p == cyc_cfg[g] - 1) ? 1 : lddel_cfg[g] + 1;
        end
        t += 1;
      end
    end
    exp_done = t;
  endtask

  task automatic mark();
    m_fire = fire_t.size(); m_req = req_t.size(); m_cmpt = cmpt_t.size();
    m_abtd = abtd_t.size(); m_rise = rise_t.size(); m_fall = fall_t.size();
    m_reqcyc = n_req_cyc;
  endtask

  task automatic start_run();
    drive_cfg();
    @(posedge clk125); #1;
    mark();
    cap_trig = 1'b1;
    @(posedge clk125); #1;
    base = cyc_now;
    cap_trig = 1'b0;
  endtask

  task automatic run_to_end(input int inj_trig, input int inj_abort, input int budget);
    int off, tail;
    tail = -1;
    for (int k = 0; k < budget; k++) begin
      off = cyc_now - base;
      cap_trig  = (off == inj_trig);
      cap_abort = (off == inj_abort);
      if (inj_abort >= 0 && off == inj_abort + 1) begin
        check("abort_cing", cap_cing, 0);
        check("abort_relay", relay_out, 0);
        check("abort_lmh", lmh_out, 0);
        check("abort_abtd", cap_abtd, 1);
        check("abort_req", dac_req, 0);
        check("abort_daca_hold", dac_a, daca_cfg[0]);
      end
      if (tail < 0 && (cmpt_t.size() > m_cmpt || abtd_t.size() > m_abtd)) tail = 6;
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(posedge clk125); #1;
    end
    cap_trig  = 1'b0;
    cap_abort = 1'b0;
  endtask

  task automatic compare_run(input string tag, input bit aborted);
    int nf, nr, nc;
    nf = fire_t.size() - m_fire;
    check({tag, "_npulse"}, nf, exp_t.size());
    for (int i = 0; i < nf && i < exp_t.size(); i++) begin
      check($sformatf("%s_t%0d", tag, i), fire_t[m_fire+i] - base, exp_t[i]);
      check($sformatf("%s_idx%0d", tag, i), fire_idx[m_fire+i], exp_g[i]);
      check($sformatf("%s_rly%0d", tag, i), fire_rly[m_fire+i], rly_cfg[exp_g[i]]);
      check($sformatf("%s_lmh%0d", tag, i), fire_lmh[m_fire+i], lmh_cfg[exp_g[i]]);
    end
    nr = req_t.size() - m_req;
    check({tag, "_nreq"}, nr, exp_req_t.size());
    for (int i = 0; i < nr && i < exp_req_t.size(); i++) begin
      check($sformatf("%s_reqt%0d", tag, i), req_t[m_req+i] - base, exp_req_t[i]);
      check($sformatf("%s_daca%0d", tag, i), req_a[m_req+i], daca_cfg[exp_req_g[i]]);
      check($sformatf("%s_dacb%0d", tag, i), req_b[m_req+i], dacb_cfg[exp_req_g[i]]);
    end
    nc = cmpt_t.size() - m_cmpt;
    if (aborted) begin
      check({tag, "_ncmpt"}, nc, 0);
      check({tag, "_nabtd"}, abtd_t.size() - m_abtd, 1);
    end else begin
      check({tag, "_ncmpt"}, nc, 1);
      if (nc > 0) check({tag, "_cmpt_t"}, cmpt_t[m_cmpt] - base, exp_done);
      check({tag, "_nabtd"}, abtd_t.size() - m_abtd, 0);
      check({tag, "_nrise"}, rise_t.size() - m_rise, 1);
      if (rise_t.size() > m_rise) check({tag, "_rise_t"}, rise_t[m_rise] - base, 0);
      if (fall_t.size() > m_fall) check({tag, "_fall_t"}, fall_t[m_fall] - base, exp_done);
      else check({tag, "_fall_seen"}, 0, 1);
      check({tag, "_idx_hold"}, cap_gain_idx, exp_n - 1);
    end
  endtask

  task automatic basic_cfg();
    cfg_cnt = 2; cfg_gdel = 4;
    cyc_cfg   = '{3, 2, 0, 0};
    lddel_cfg = '{2, 0, 1, 1};
    random_words();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {dac_req, ld_fire, cap_cing, cap_cmpt, cap_abtd, cap_err}, 0);
    check({tag, "_daca"}, dac_a, 0);
    check({tag, "_dacb"}, dac_b, 0);
    check({tag, "_lmh"}, lmh_out, 0);
    check({tag, "_relay"}, relay_out, 0);
    check({tag, "_idx"}, cap_gain_idx, 0);
  endtask

  initial begin
    int ab, n0, r0, a0;
    for (int g = 0; g < 4; g++) begin
      cyc_cfg[g] = 0; lddel_cfg[g] = 0;
    end
    random_words();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk125);
    #1 check_all_zero("reset");
    #2 rst = 1'b1;

    // Basic two-gain run.
    basic_cfg(); build_model();
    start_run(); run_to_end(-1, -1, exp_done + 30);
    compare_run("basic", 0);

    // Clamp low: count 0 runs one gain.
    cfg_cnt = 0; cfg_gdel = 1;
    cyc_cfg = '{1, 5, 5, 5}; lddel_cfg = '{0, 0, 0, 0};
    random_words(); build_model();
    start_run(); run_to_end(-1, -1, exp_done + 30);
    compare_run("clamp0", 0);

    // Clamp high with gain 2 skipped.
    cfg_cnt = 7; cfg_gdel = 2;
    cyc_cfg = '{1, 1, 0, 1}; lddel_cfg = '{1, 1, 1, 1};
    random_words(); build_model();
    start_run(); run_to_end(-1, -1, exp_done + 30);
    compare_run("clamp7", 0);

    // Abort in the second WAIT of gain 0.
    cfg_cnt = 2; cfg_gdel = 2;
    cyc_cfg = '{4, 2, 0, 0}; lddel_cfg = '{3, 1, 0, 0};
    random_words(); build_model();
    ab = exp_t[1] + 2;
    while (exp_t.size() > 0 && exp_t[$] >= ab) begin
      void'(exp_t.pop_back()); void'(exp_g.pop_back());
    end
    while (exp_req_t.size() > 0 && exp_req_t[$] >= ab) begin
      void'(exp_req_t.pop_back()); void'(exp_req_g.pop_back());
    end
    start_run(); run_to_end(-1, ab, exp_done + 30);
    compare_run("abort", 1);

    // Re-trigger during FIRE is ignored.
    basic_cfg(); build_model();
    start_run(); run_to_end(-1, -1, 0);
    run_to_end(exp_t[0], -1, exp_done + 30);
    compare_run("retrig", 0);

    // Trigger together with abort in IDLE is ignored.
    @(posedge clk125); #1;
    n0 = fire_t.size(); r0 = rise_t.size(); a0 = abtd_t.size();
    cap_trig = 1'b1; cap_abort = 1'b1;
    @(posedge clk125); #1;
    cap_trig = 1'b0; cap_abort = 1'b0;
    repeat (6) @(posedge clk125);
    #1;
    check("trigabort_cing", rise_t.size() - r0, 0);
    check("trigabort_pulse", fire_t.size() - n0, 0);
    check("trigabort_abtd", abtd_t.size() - a0, 0);

    // Asynchronous reset in the middle of SETTLE, then a fresh run.
    basic_cfg(); build_model();
    start_run();
    repeat (3) @(posedge clk125);
    #3 rst = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk125);
    #2 rst = 1'b1;
    start_run(); run_to_end(-1, -1, exp_done + 30);
    compare_run("post_rst", 0);

    // Randomized runs.
    for (int r = 0; r < 5; r++) begin
      cfg_cnt  = $urandom_range(0, 7);
      cfg_gdel = $urandom_range(0, 5);
      for (int g = 0; g < 4; g++) begin
        cyc_cfg[g]   = $urandom_range(0, 3);
        lddel_cfg[g] = $urandom_range(0, 3);
      end
      random_words(); build_model();
      start_run(); run_to_end(-1, -1, exp_done + 30);
      compare_run($sformatf("rand%0d", r), 0);
    end

`ifdef CAP_DAC_TIMEOUT_EN
    // Withheld acknowledge trips the watchdog after DAC_TO request cycles.
    ack_en = 1'b0;
    cfg_cnt = 1; cfg_gdel = 1;
    cyc_cfg = '{1, 0, 0, 0}; lddel_cfg = '{0, 0, 0, 0};
    random_words(); build_model();
    start_run();
    for (int k = 0; k < 60; k++) begin
      if (abtd_t.size() > m_abtd) break;
      @(posedge clk125); #1;
    end
    check("tmo_nabtd", abtd_t.size() - m_abtd, 1);
    if (abtd_t.size() > m_abtd) check("tmo_abtd_t", abtd_t[m_abtd] - base, TB_DAC_TO);
    check("tmo_reqcyc", n_req_cyc - m_reqcyc, TB_DAC_TO);
    check("tmo_err", cap_err, 1);
    check("tmo_ncmpt", cmpt_t.size() - m_cmpt, 0);
    repeat (3) @(posedge clk125);
    #1 check("tmo_err_sticky", cap_err, 1);
    ack_en = 1'b1;
    start_run();
    check("tmo_err_clear", cap_err, 0);
    run_to_end(-1, -1, exp_done + 30);
    compare_run("tmo_next", 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cap_gain_seq.md
Name: cap_gain_seq

Overview:
- Sequencer for the multi-gain capture operation.
- On a capture trigger it steps through the configured gains in order 0..N-1. For each gain it:
  - applies the relay, LMH and DAC settings;
  - waits for the settle delay;
  - fires the configured number of LD pulses, each followed by its inter-pulse delay.
- Drives the capture-in-progress and capture-complete status back to the GP control logic.
- Sits between the capture GP register file (configuration source) and the analog front-end, laser-driver and DAC loader.

Parameters:
- CYC_W, 18, width of the per-gain pulse-cycle count.
- DEL_W, 32, width of the settle delay and of the per-gain LD delay.
- DAC_W, 32, width of each DAC word.
- LMH_W, 6, width of the per-gain LMH code.
- RLY_W, 4, width of the per-gain relay code.
- DAC_TO, 1024, DAC acknowledge watchdog limit in cycles (used only with the optional feature).

Ports:
- clk125  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cap_trig  in  1  one-cycle capture start pulse.
- cap_abort  in  1  level; aborts the sequence.
- cap_gain_number  in  3  number of gains to run; 0 is treated as 1, values >4 are treated as 4.
- cap_gain_del  in  DEL_W  settle cycles after each gain is applied.
- cap_cycle_bus  in  4*CYC_W  per-gain pulse count; gain g occupies [g*CYC_W +: CYC_W].
- cap_lddel_bus  in  4*DEL_W  per-gain inter-pulse delay.
- cap_daca_bus  in  4*DAC_W  per-gain DAC A word.
- cap_dacb_bus  in  4*DAC_W  per-gain DAC B word.
- cap_lmh_bus  in  4*LMH_W  per-gain LMH code.
- cap_relay_bus  in  4*RLY_W  per-gain relay code.
- dac_ack  in  1  DAC loader done pulse.
- dac_req  out  1  DAC load request; level, held until ack.
- dac_a  out  DAC_W  registered DAC A word.
- dac_b  out  DAC_W  registered DAC B word.
- lmh_out  out  LMH_W  registered LMH code.
- relay_out  out  RLY_W  registered relay code.
- ld_fire  out  1  one-cycle laser-driver pulse.
- cap_gain_idx  out  2  gain currently being run.
- cap_cing  out  1  capture in progress.
- cap_cmpt  out  1  one-cycle completion pulse.
- cap_abtd  out  1  one-cycle abort pulse.
- cap_err  out  1  sticky DAC timeout flag.

Behaviour:
- Reset values: all outputs 0; state IDLE. This includes dac_a, dac_b, lmh_out, relay_out and cap_err.
- States: IDLE, APPLY, SETTLE, FIRE, WAIT, NEXT, DONE.
- IDLE:
  - cap_trig=1 and cap_abort=0: latch the clamped gain count, set idx=0, go to APPLY.
  - cap_cing rises in the first APPLY cycle, i.e. trigger + 1.
  - cap_trig outside IDLE is ignored.
- APPLY:
  - On entry, register the relay, LMH and DAC words of gain idx onto the outputs.
  - Load the cycle counter from cap_cycle_bus[idx].
  - If that count is 0, go to NEXT; the gain is skipped with no dac_req and no outputs changed.
  - Otherwise assert dac_req from the entry cycle until dac_ack is sampled high; dac_req drops the cycle after the ack.
  - Then go to SETTLE with the delay counter = cap_gain_del.
- SETTLE:
  - Lasts max(cap_gain_del,1) cycles.
  - cap_gain_del is sampled at APPLY entry; changes while busy do not affect the current gain.
- FIRE:
  - ld_fire=1 for exactly one cycle; decrement the cycle counter.
  - Remaining count 0: go to NEXT.
  - Else Lddel[idx]=0: stay in FIRE, giving back-to-back pulses.
  - Else go to WAIT for Lddel cycles.
  - Net pulse period = Lddel+1 cycles.
- WAIT: counts down, then returns to FIRE.
- NEXT:
  - idx+1 < count: idx++, go to APPLY.
  - Else go to DONE.
- DONE: cap_cmpt=1 for one cycle, cap_cing falls the same cycle, return to IDLE.
- cap_abort=1 in any non-IDLE state:
  - Next cycle: IDLE, cap_cing=0, relay_out=0, lmh_out=0, dac_req=0.
  - cap_abtd pulses for one cycle; no cap_cmpt.
  - ld_fire is never asserted in the abort cycle.
  - dac_a and dac_b hold their last values.
- Simultaneous cap_abort and cap_trig in IDLE: the trigger is ignored.
- Counters saturate and never wrap. The delay counter is DEL_W bits and the cycle counter is CYC_W bits.
- cap_gain_idx holds its last value in IDLE and is reset to 0 on a new trigger.
- Total ld_fire pulses per run = sum of cycle[g] for g < count.

Optional Feature:
- Macro: CAP_DAC_TIMEOUT_EN.
- Defined:
  - In APPLY a watchdog counts cycles while dac_req=1.
  - On reaching DAC_TO without dac_ack: set cap_err (sticky until reset or the next cap_trig), then take the abort path, including the cap_abtd pulse.
- Undefined:
  - APPLY waits for dac_ack indefinitely.
  - cap_err is tied to 0.

Test Plan:
- Basic run:
  - Stimulus: count=2; gain_del=4; gain0 cycle=3, Lddel=2; gain1 cycle=2, Lddel=0; dac_ack returned 1 cycle after each req.
  - Required: 5 ld_fire pulses; gain0 pulses spaced 3 cycles; gain1 pulses on consecutive cycles; 2 dac_req handshakes; relay_out and lmh_out switch to the gain1 values at the second APPLY; one cap_cmpt; cap_cing high from trigger+1 to the cmpt cycle.
- Clamping and skipping:
  - Stimulus: count=0 with gain0 cycle=1; then count=7 with gain2 cycle=0 and the other gains at 1.
  - Required: first run gives exactly 1 pulse; second run gives 3 pulses, cap_gain_idx visits 0, 1, 3, and no dac_req is issued for gain 2.
- Abort:
  - Stimulus: cap_abort asserted during the second WAIT of gain0.
  - Required: next cycle cap_cing=0, relay_out=0, cap_abtd=1; no further ld_fire; no cap_cmpt.
- Trigger handling:
  - Stimulus: cap_trig re-pulsed during FIRE; separately, cap_trig and cap_abort together in IDLE.
  - Required: both are ignored; the pulse count is unchanged and cap_cing stays low for the second case.
- Reset:
  - Stimulus: rst asserted low mid-SETTLE, asynchronously between clock edges.
  - Required: all outputs 0 immediately; a trigger after release starts a full fresh run.
- Timeout (CAP_DAC_TIMEOUT_EN, DAC_TO=16):
  - Stimulus: dac_ack withheld.
  - Required: cap_err=1 and cap_abtd=1 after 16 request cycles; cap_err clears on the next cap_trig.
